ipv4_header_update: RTL and testbench

IPV4_HEADER_UPDATE -- requirements
Module: ipv4_header_update

---
 rtl/ipv4_header_update.sv | 194 +++++++++++++++++++
 tb/tb_ipv4_header_update.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_header_update.sv
`default_nettype none
// ============================================================================
// Module : ipv4_header_update
// Brief  : Patches TTL/checksum of IPv4 header beats; marks bad or expired packets for drop
// Rev    : 1.0
// ============================================================================
module ipv4_header_update #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int DST_PORT_POS         = 24
) (
   input  logic                               AXI_ACLK,
   input  logic                               AXI_RESET,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]     S_AXIS_TDATA,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    S_AXIS_TUSER,
   input  logic                               S_AXIS_TVALID,
   input  logic                               S_AXIS_TLAST,
   output logic                               S_AXIS_TREADY,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]    M_AXIS_TUSER,
   output logic                               M_AXIS_TVALID,
   output logic                               M_AXIS_TLAST,
   input  logic                               M_AXIS_TREADY,
   input  logic [31:0]                        checksum_in,
   input  logic                               checksum_in_valid,
   output logic [31:0]                        bad_csum_count,
   output logic [31:0]                        ttl_expired_count,
   output logic                               csum_overrun
);

   localparam int DEPTH = 4;
   localparam int DW    = C_S_AXIS_DATA_WIDTH;
   localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;
   localparam int UW    = C_S_AXIS_TUSER_WIDTH;

   typedef enum logic [1:0] {
      HDR_WAIT = 2'd0,
      HDR_SEND = 2'd1,
      BODY     = 2'd2
   } state_t;

   state_t state, state_next;

   logic [DW-1:0] fifo_data [DEPTH];
   logic [KW-1:0] fifo_strb [DEPTH];
   logic [UW-1:0] fifo_user [DEPTH];
   logic          fifo_last [DEPTH];
   logic [1:0]    wr_ptr, rd_ptr;
   logic [2:0]    count;
   logic          empty, nearly_full, wr_en, rd_en;

   logic [DW-1:0] head_data, hdr_data;
   logic [KW-1:0] head_strb;
   logic [UW-1:0] head_user, hdr_user;
   logic          head_last;

   logic [31:0]   hold_sum;
   logic          hold_full, hdr_xfer, out_valid;

   logic [15:0]   ethertype, hdr_csum, fold, csum_new;
   logic [7:0]    ver_ihl, ttl;
   logic [16:0]   fold1, csum_inc;
   logic          is_ipv4, csum_good, ttl_expired, drop, update;

   // Fall-through FIFO: the head entry is visible the cycle after it is written.
   assign empty         = (count == 3'd0);
   assign nearly_full   = (count >= 3'(DEPTH - 1));
   assign S_AXIS_TREADY = !nearly_full;
   assign wr_en         = S_AXIS_TVALID && !nearly_full;
   assign rd_en         = out_valid && M_AXIS_TREADY;

   always_ff @(posedge AXI_ACLK) begin
      if (wr_en) begin
         fifo_data[wr_ptr] <= S_AXIS_TDATA;
         fifo_strb[wr_ptr] <= S_AXIS_TSTRB;
         fifo_user[wr_ptr] <= S_AXIS_TUSER;
         fifo_last[wr_ptr] <= S_AXIS_TLAST;
      end
   end

   always_ff @(posedge AXI_ACLK) begin
      if (AXI_RESET) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 2'd1;
         if (rd_en) rd_ptr <= rd_ptr + 2'd1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   assign head_data = fifo_data[rd_ptr];
   assign head_strb = fifo_strb[rd_ptr];
   assign head_user = fifo_user[rd_ptr];
   assign head_last = fifo_last[rd_ptr];

   assign ethertype = head_data[159:144];
   assign ver_ihl   = head_data[143:136];
   assign ttl       = head_data[79:72];
   assign hdr_csum  = head_data[63:48];

   assign is_ipv4     = (ethertype == 16'h0800) && (ver_ihl == 8'h45);
   assign fold1       = {1'b0, hold_sum[31:16]} + {1'b0, hold_sum[15:0]};
   assign fold        = fold1[15:0] + {15'd0, fold1[16]};
   assign csum_good   = (fold == 16'hFFFF);
   assign ttl_expired = (ttl <= 8'd1);
   // Decrementing TTL lowers the header sum by 0x0100, so the stored complement rises by it.
   assign csum_inc    = {1'b0, hdr_csum} + 17'h00100;
   assign csum_new    = csum_inc[15:0] + {15'd0, csum_inc[16]};
   assign drop        = is_ipv4 && (!csum_good || ttl_expired);
   assign update      = is_ipv4 && csum_good && !ttl_expired;

   always_comb begin
      hdr_data = head_data;
      hdr_user = head_user;
      if (update) begin
         hdr_data[79:72] = ttl - 8'd1;
         hdr_data[63:48] = csum_new;
      end
      if (drop) begin
         hdr_user[DST_PORT_POS +: 8] = 8'd0;
      end
   end

   always_comb begin
      state_next = state;
      out_valid  = 1'b0;
      case (state)
         HDR_WAIT: begin
            if (!empty && hold_full) state_next = HDR_SEND;
         end
         HDR_SEND: begin
            out_valid = 1'b1;
            if (M_AXIS_TREADY) state_next = head_last ? HDR_WAIT : BODY;
         end
         BODY: begin
            out_valid = !empty;
            if (!empty && M_AXIS_TREADY && head_last) state_next = HDR_WAIT;
         end
         default: state_next = HDR_WAIT;
      endcase
   end

   always_ff @(posedge AXI_ACLK) begin
      if (AXI_RESET) state <= HDR_WAIT;
      else           state <= state_next;
   end

   assign hdr_xfer      = (state == HDR_SEND) && M_AXIS_TREADY;
   assign M_AXIS_TVALID = out_valid;
   assign M_AXIS_TDATA  = (state == HDR_SEND) ? hdr_data : head_data;
   assign M_AXIS_TUSER  = (state == HDR_SEND) ? hdr_user : head_user;
   assign M_AXIS_TSTRB  = head_strb;
   assign M_AXIS_TLAST  = head_last;

   // A strobe landing on the header-release cycle belongs to the next packet.
   always_ff @(posedge AXI_ACLK) begin
      if (AXI_RESET) begin
         hold_sum     <= 32'd0;
         hold_full    <= 1'b0;
         csum_overrun <= 1'b0;
      end else if (checksum_in_valid) begin
         if (!hold_full || hdr_xfer) hold_sum <= checksum_in;
         else                        csum_overrun <= 1'b1;
         hold_full <= 1'b1;
      end else if (hdr_xfer) begin
         hold_full <= 1'b0;
      end
   end

   always_ff @(posedge AXI_ACLK) begin
      if (AXI_RESET) begin
         bad_csum_count    <= 32'd0;
         ttl_expired_count <= 32'd0;
      end else if (hdr_xfer && is_ipv4) begin
         if (!csum_good) begin
            if (bad_csum_count != 32'hFFFF_FFFF) bad_csum_count <= bad_csum_count + 32'd1;
         end else if (ttl_expired) begin
            if (ttl_expired_count != 32'hFFFF_FFFF) ttl_expired_count <= ttl_expired_count + 32'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ipv4_header_update.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_ipv4_header_update
// Brief  : Directed table, corner sequences and randomized packets against a reference model
// Rev    : 1.0
// ============================================================================
module tb_ipv4_header_update;

   localparam int DST = 24;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] s_tdata;
   logic [31:0]  s_tstrb;
   logic [127:0] s_tuser;
   logic         s_tvalid, s_tlast, s_tready;
   logic [255:0] m_tdata;
   logic [31:0]  m_tstrb;
   logic [127:0] m_tuser;
   logic         m_tvalid, m_tlast, m_tready;
   logic [31:0]  csum_in;
   logic         csum_v;
   logic [31:0]  bad_cnt, ttl_cnt;
   logic         overrun;

   always #5 clk = ~clk;

   ipv4_header_update dut (
      .AXI_ACLK          (clk),
      .AXI_RESET         (rst),
      .S_AXIS_TDATA      (s_tdata),
      .S_AXIS_TSTRB      (s_tstrb),
      .S_AXIS_TUSER      (s_tuser),
      .S_AXIS_TVALID     (s_tvalid),
      .S_AXIS_TLAST      (s_tlast),
      .S_AXIS_TREADY     (s_tready),
      .M_AXIS_TDATA      (m_tdata),
      .M_AXIS_TSTRB      (m_tstrb),
      .M_AXIS_TUSER      (m_tuser),
      .M_AXIS_TVALID     (m_tvalid),
      .M_AXIS_TLAST      (m_tlast),
      .M_AXIS_TREADY     (m_tready),
      .checksum_in       (csum_in),
      .checksum_in_valid (csum_v),
      .bad_csum_count    (bad_cnt),
      .ttl_expired_count (ttl_cnt),
      .csum_overrun      (overrun)
   );

   typedef struct packed {
      logic [255:0] d;
      logic [31:0]  k;
      logic [127:0] u;
      logic         l;
   } beat_t;

   typedef struct packed {
      logic [15:0] eth, hw0, hw4, hw5, hw6;
      logic [31:0] sum;
      logic [7:0]  ettl;
      logic [15:0] ecs;
      logic        edrop, ebad, etx;
   } vec_t;

   int    checks = 0, errors = 0;
   int    hdr_seen = 0, hdr_pushed = 0;
   int    exp_bad = 0, exp_ttlx = 0;
   int    ready_mode = 0;
   beat_t exp_q[$];
   vec_t  tbl[12];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] r256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [127:0] r128();
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] mk_hdr(input vec_t v);
      logic [255:0] d;
      d = r256();
      d[159:144] = v.eth;  d[143:128] = v.hw0;     d[127:112] = 16'h0073;
      d[111:96]  = 16'h0000; d[95:80]  = 16'h4000; d[79:64]   = v.hw4;
      d[63:48]   = v.hw5;  d[47:32]   = v.hw6;     d[31:16]   = 16'h0001;
      d[15:0]    = 16'hC0A8;
      return d;
   endfunction

   // Reference: ones-complement sum is valid iff it is a nonzero multiple of 0xFFFF.
   task automatic ref_hdr(input logic [255:0] d, input logic [127:0] u, input logic [31:0] s,
                          output logic [255:0] od, output logic [127:0] ou,
                          output int bad, output int tx);
      int unsigned c;
      od = d; ou = u; bad = 0; tx = 0;
      if (d[159:144] == 16'h0800 && d[143:136] == 8'h45) begin
         if (s == 32'd0 || ({32'd0, s} % 64'd65535) != 64'd0) begin
            bad = 1;
            ou[DST +: 8] = 8'd0;
         end else if (d[79:72] < 8'd2) begin
            tx = 1;
            ou[DST +: 8] = 8'd0;
         end else begin
            od[79:72] = d[79:72] - 8'd1;
            c = int'(d[63:48]) + 256;
            if (c > 65535) c = c - 65535;
            od[63:48] = c[15:0];
         end
      end
   endtask

   task automatic send_beat(input beat_t b);
      int n;
      bit acc;
      n = 0; acc = 0;
      s_tdata = b.d; s_tstrb = b.k; s_tuser = b.u; s_tlast = b.l; s_tvalid = 1'b1;
      while (!acc && n < 500) begin
         @(negedge clk);
         acc = s_tready;
         tick();
         n++;
      end
      s_tvalid = 1'b0;
      if (!acc) begin
         checks++; errors++;
         $display("FAIL send_timeout: got no ready within %0d cycles", n);
      end
   endtask

   task automatic pulse(input logic [31:0] s);
      csum_in = s; csum_v = 1'b1;
      tick();
      csum_v = 1'b0;
   endtask

   task automatic wait_free();
      int n;
      n = 0;
      while (hdr_seen != hdr_pushed && n < 2000) begin tick(); n++; end
      if (hdr_seen != hdr_pushed) begin
         checks++; errors++;
         $display("FAIL hdr_wait_timeout: got %0d headers expected %0d", hdr_seen, hdr_pushed);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 4000) begin tick(); n++; end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      end
   endtask

   task automatic check_tvalid_low(input int cycles, input string name);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         chk(name, m_tvalid, 1'b0);
         tick();
      end
   endtask

   // Output monitor: scoreboards every handshake and checks hold-stability under backpressure.
   initial begin
      beat_t cur, pb, e;
      logic  pv, pr, prst, in_pkt;
      pv = 0; pr = 0; prst = 1; in_pkt = 0; pb = '0;
      forever begin
         @(negedge clk);
         cur = {m_tdata, m_tstrb, m_tuser, m_tlast};
         if (!rst && !prst && pv && !pr) begin
            chk("stable_tvalid", m_tvalid, 1'b1);
            checks++;
            if (cur !== pb) begin
               errors++;
               $display("FAIL stable_beat: got d=%h u=%h expected d=%h u=%h", cur.d, cur.u, pb.d, pb.u);
            end
         end
         if (rst) begin
            in_pkt = 0;
         end else if (m_tvalid && m_tready) begin
            if (!in_pkt) hdr_seen++;
            in_pkt = !m_tlast;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL out_beat: got unexpected beat d=%h expected none", cur.d);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  errors++;
                  $display("FAIL out_beat: got d=%h k=%h u=%h l=%b expected d=%h k=%h u=%h l=%b",
                           cur.d, cur.k, cur.u, cur.l, e.d, e.k, e.u, e.l);
               end
            end
         end
         pv = m_tvalid; pr = m_tready; prst = rst; pb = cur;
      end
   end

   initial begin
      m_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            2:       m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = 1'b0;
         endcase
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   task automatic rand_pkt();
      beat_t        hb, b;
      beat_t        body[$];
      logic [255:0] d, od;
      logic [127:0] u, ou;
      logic [31:0]  partial, csum, sum;
      logic [15:0]  hw9;
      int           n, bad, tx;
      n = $urandom_range(1, 5);
      d = r256();
      if ($urandom_range(0, 9) < 8) d[159:144] = 16'h0800;
      if ($urandom_range(0, 9) < 9) d[143:136] = 8'h45;
      case ($urandom_range(0, 3))
         0: d[79:72] = 8'd0;
         1: d[79:72] = 8'd1;
         2: d[79:72] = 8'd2;
         default: ;
      endcase
      hw9 = 16'($urandom);
      partial = {16'd0, hw9};
      for (int i = 0; i < 9; i++)
         if (i != 5) partial += {16'd0, d[143-16*i -: 16]};
      if ($urandom_range(0, 9) < 7) csum = 32'd65535 - (partial % 32'd65535);
      else                          csum = {16'd0, 16'($urandom)};
      d[63:48] = csum[15:0];
      sum = partial + {16'd0, csum[15:0]};
      u = r128();
      ref_hdr(d, u, sum, od, ou, bad, tx);
      hb = {d, 32'($urandom), u, 1'(n == 1)};
      wait_free();
      hdr_pushed++;
      exp_q.push_back({od, hb.k, ou, hb.l});
      for (int i = 1; i < n; i++) begin
         b = {r256(), 32'($urandom), r128(), 1'(i == n - 1)};
         body.push_back(b);
         exp_q.push_back(b);
      end
      exp_bad += bad; exp_ttlx += tx;
      if ($urandom_range(0, 1) == 0) begin
         pulse(sum);
         send_beat(hb);
      end else begin
         send_beat(hb);
         repeat ($urandom_range(0, 3)) tick();
         pulse(sum);
      end
      foreach (body[i]) begin
         send_beat(body[i]);
         if ($urandom_range(0, 3) == 0) tick();
      end
   endtask

   initial begin
      beat_t hb, b, eb;
      vec_t  v;
      rst = 1'b1; s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      csum_in = '0; csum_v = 1'b0;
      tbl[0]  = '{16'h0800, 16'h4500, 16'h4011, 16'hB861, 16'hC0A8, 32'h0004FFFB, 8'h3F, 16'hB961, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{16'h0800, 16'h4500, 16'h4011, 16'hB860, 16'hC0A8, 32'h0004FFFA, 8'h40, 16'hB860, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{16'h0800, 16'h4500, 16'h0111, 16'hF761, 16'hC0A8, 32'h0002FFFD, 8'h01, 16'hF761, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{16'h0800, 16'h4500, 16'h4011, 16'hFF00, 16'h7A09, 32'h0002FFFD, 8'h3F, 16'h0001, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{16'h0800, 16'h4500, 16'h0011, 16'hB861, 16'hC0A8, 32'h0001FFFD, 8'h00, 16'hB861, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{16'h0800, 16'h4500, 16'h0211, 16'hF661, 16'hC0A8, 32'h0002FFFD, 8'h01, 16'hF761, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{16'h86DD, 16'h4500, 16'h4011, 16'hB861, 16'hC0A8, 32'h0004FFFB, 8'h40, 16'hB861, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{16'h0800, 16'h4600, 16'h4011, 16'hB861, 16'hC0A8, 32'h0002FFFD, 8'h40, 16'hB861, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{16'h0806, 16'h4500, 16'h4011, 16'hB861, 16'hC0A8, 32'h00000000, 8'h40, 16'hB861, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{16'h0800, 16'h4500, 16'h4011, 16'hB861, 16'hC0A8, 32'h00000000, 8'h40, 16'hB861, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{16'h0800, 16'h4500, 16'h4011, 16'hB861, 16'hC0A8, 32'hFFFF0000, 8'h3F, 16'hB961, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{16'h0800, 16'h4500, 16'h4011, 16'hB861, 16'hC0A8, 32'hFFFFFFFF, 8'h3F, 16'hB961, 1'b0, 1'b0, 1'b0};

      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_tvalid", m_tvalid, 1'b0);
      chk("reset_s_tready", s_tready, 1'b1);
      chk("reset_bad_cnt", bad_cnt, 32'd0);
      chk("reset_ttl_cnt", ttl_cnt, 32'd0);
      chk("reset_overrun", overrun, 1'b0);
      tick();

      // Directed table: header beat plus one body beat per vector.
      foreach (tbl[i]) begin
         v = tbl[i];
         hb = {mk_hdr(v), 32'($urandom), r128(), 1'b0};
         hb.u[DST +: 8] = 8'h04;
         b  = {r256(), 32'($urandom), r128(), 1'b1};
         eb = hb;
         eb.d[79:72] = v.ettl;
         eb.d[63:48] = v.ecs;
         if (v.edrop) eb.u[DST +: 8] = 8'h00;
         wait_free();
         hdr_pushed++;
         exp_q.push_back(eb);
         exp_q.push_back(b);
         exp_bad += int'(v.ebad); exp_ttlx += int'(v.etx);
         pulse(v.sum);
         send_beat(hb);
         send_beat(b);
      end
      drain();
      chk("table_bad_cnt", bad_cnt, 32'(exp_bad));
      chk("table_ttl_cnt", ttl_cnt, 32'(exp_ttlx));

      // Header waits for a late sum; then 4 beats under alternating backpressure.
      wait_free();
      ready_mode = 1;
      hb = {mk_hdr(tbl[0]), 32'hFFFFFFFF, r128(), 1'b0};
      eb = hb; eb.d[79:72] = 8'h3F; eb.d[63:48] = 16'hB961;
      hdr_pushed++;
      exp_q.push_back(eb);
      send_beat(hb);
      check_tvalid_low(5, "late_sum_tvalid");
      pulse(32'h0004FFFB);
      for (int i = 0; i < 3; i++) begin
         b = {r256(), 32'($urandom), r128(), 1'(i == 2)};
         exp_q.push_back(b);
         send_beat(b);
      end
      drain();
      ready_mode = 0;

      // Second strobe with no header in between must be ignored and flagged.
      wait_free();
      chk("overrun_before", overrun, 1'b0);
      pulse(32'h0004FFFB);
      pulse(32'h0004FFFA);
      @(negedge clk);
      chk("overrun_set", overrun, 1'b1);
      tick();
      hb = {mk_hdr(tbl[0]), 32'($urandom), r128(), 1'b1};
      eb = hb; eb.d[79:72] = 8'h3F; eb.d[63:48] = 16'hB961;
      hdr_pushed++;
      exp_q.push_back(eb);
      send_beat(hb);
      drain();
      chk("overrun_sticky", overrun, 1'b1);
      chk("overrun_bad_cnt", bad_cnt, 32'(exp_bad));

      // Reset in the middle of a stalled packet.
      ready_mode = 3;
      wait_free();
      pulse(32'h0004FFFB);
      send_beat({mk_hdr(tbl[0]), 32'hFFFFFFFF, r128(), 1'b0});
      s_tdata = r256(); s_tvalid = 1'b1; s_tlast = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; s_tvalid = 1'b0;
      @(negedge clk);
      chk("midrst_tvalid", m_tvalid, 1'b0);
      chk("midrst_s_tready", s_tready, 1'b1);
      chk("midrst_bad_cnt", bad_cnt, 32'd0);
      chk("midrst_ttl_cnt", ttl_cnt, 32'd0);
      chk("midrst_overrun", overrun, 1'b0);
      tick();
      exp_bad = 0; exp_ttlx = 0;
      ready_mode = 0;
      v = tbl[5];
      hb = {mk_hdr(v), 32'($urandom), r128(), 1'b0};
      eb = hb; eb.d[79:72] = 8'h01; eb.d[63:48] = 16'hF761;
      b  = {r256(), 32'($urandom), r128(), 1'b1};
      hdr_pushed++;
      exp_q.push_back(eb);
      exp_q.push_back(b);
      send_beat(hb);
      check_tvalid_low(3, "postrst_no_sum");
      pulse(v.sum);
      send_beat(b);
      drain();

      // Randomized packets against the reference model.
      ready_mode = 2;
      for (int p = 0; p < 60; p++) rand_pkt();
      drain();
      ready_mode = 0;
      tick();
      chk("final_bad_cnt", bad_cnt, 32'(exp_bad));
      chk("final_ttl_cnt", ttl_cnt, 32'(exp_ttlx));
      chk("final_overrun", overrun, 1'b0);
      chk("final_headers", 32'(hdr_seen), 32'(hdr_pushed));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
